// File: rtl/w_stage_ctrl.sv
// Writeback-stage controller: registers the X->W control fields, decodes
// register-file / CSR write enables and holds loads in W until memory completes.
module w_stage_ctrl #(
  parameter int unsigned MEM_LAT   = 0,
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x_valid,
  input  logic [6:0]           x_opcode,
  input  logic [2:0]           x_funct3,
  input  logic [4:0]           x_rd,
  input  logic                 flush,
  input  logic                 dmem_resp_valid,
  output logic                 w_stall,
  output logic                 w_valid,
  output logic [4:0]           w_rd,
  output logic [1:0]           wb_sel,
  output logic                 rwe,
  output logic                 csr_we,
  output logic                 w_commit,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ARI_I  = 7'b0010011;
  localparam logic [6:0] OP_ARI_R  = 7'b0110011;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  localparam int unsigned CNT_W = (MEM_LAT > 32'd1) ? $clog2(MEM_LAT + 32'd1) : 1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q;
  logic [6:0]             opcode_q;
  logic [2:0]             funct3_q;
  logic [4:0]             rd_q;
  logic [INSTRET_W-1:0]   instret_q;

  logic                   done_s;
  logic                   enter_wait_s;
  logic                   wr_cls_s;

  // With MEM_LAT=1 a load completes in its only W cycle, so it never waits.
  assign enter_wait_s = x_valid & ~flush & (x_opcode == OP_LOAD) & (MEM_LAT != 32'd1);
  assign done_s       = (MEM_LAT == 32'd0) ? dmem_resp_valid : (cnt_q == CNT_W'(1));

  // State register, load counter, W pipeline register and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= {CNT_W{1'b0}};
      valid_q   <= 1'b0;
      opcode_q  <= 7'd0;
      funct3_q  <= 3'd0;
      rd_q      <= 5'd0;
      instret_q <= {INSTRET_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!w_stall) begin
        valid_q  <= x_valid & ~flush;
        opcode_q <= x_opcode;
        funct3_q <= x_funct3;
        rd_q     <= x_rd;
      end
      if (w_commit) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
    end
  end

  // Next-state logic for the load wait FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (enter_wait_s) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(MEM_LAT);
        end else begin
          state_d = ST_RUN;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      ST_WAIT: begin
        if (done_s) begin
          // The next instruction is captured at the completing edge.
          if (enter_wait_s) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(MEM_LAT);
          end else begin
            state_d = ST_RUN;
            cnt_d   = {CNT_W{1'b0}};
          end
        end else begin
          state_d = ST_WAIT;
          cnt_d   = (cnt_q != {CNT_W{1'b0}}) ? (cnt_q - CNT_W'(1)) : cnt_q;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode from the W register and FSM
  always_comb begin
    wb_sel   = 2'b11;
    wr_cls_s = 1'b0;
    if (valid_q) begin
      case (opcode_q)
        OP_CSR: begin
          wb_sel   = 2'b00;
          wr_cls_s = 1'b0;
        end
        OP_AUIPC, OP_LUI, OP_ARI_R, OP_ARI_I: begin
          wb_sel   = 2'b00;
          wr_cls_s = 1'b1;
        end
        OP_LOAD: begin
          wb_sel   = 2'b01;
          wr_cls_s = 1'b1;
        end
        OP_JAL, OP_JALR: begin
          wb_sel   = 2'b10;
          wr_cls_s = 1'b1;
        end
        default: begin
          wb_sel   = 2'b11;
          wr_cls_s = 1'b0;
        end
      endcase
    end else begin
      wb_sel   = 2'b11;
      wr_cls_s = 1'b0;
    end
    w_stall  = (state_q == ST_WAIT) & ~done_s;
    w_valid  = valid_q;
    w_rd     = valid_q ? rd_q : 5'd0;
    w_commit = valid_q & ~w_stall;
    rwe      = valid_q & wr_cls_s & ~w_stall & (rd_q != 5'd0);
    // Only CSRRW / CSRRWI write; set/clear forms are treated as reads here.
    csr_we   = valid_q & (opcode_q == OP_CSR) & ~w_stall &
               ((funct3_q == 3'b001) | (funct3_q == 3'b101));
    instret  = instret_q;
  end

endmodule

// File: doc/w_stage_ctrl.md
# w_stage_ctrl

Registered, stall-capable writeback controller for the W stage of the 3-stage RV32I pipeline. Captures the X→W control fields every cycle and decodes register-file and CSR write controls from the registered instruction. Holds loads in W until data memory completes, in either a fixed-latency or a response-handshake mode, and back-pressures upstream while doing so. Drives `w_rd` for forwarding and a retired-instruction counter.

## Interface
- `MEM_LAT`, 0: data memory load latency in cycles; 0 = variable latency via `dmem_resp_valid`; N≥1 = load occupies W for exactly N cycles.
- `INSTRET_W`, 32: width of the retired-instruction counter.

- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  synchronous, active-high.
- `x_valid`  in  1  X stage holds a real instruction.
- `x_opcode`  in  7  opcode of the X-stage instruction.
- `x_funct3`  in  3  funct3 of the X-stage instruction.
- `x_rd`  in  5  destination register of the X-stage instruction.
- `flush`  in  1  the X-stage instruction is captured as a bubble.
- `dmem_resp_valid`  in  1  load data valid this cycle; used only when `MEM_LAT`=0.
- `w_stall`  out  1  W is occupied by an incomplete load; upstream must freeze.
- `w_valid`  out  1  W holds a real instruction.
- `w_rd`  out  5  rd of the W instruction; 0 when `w_valid`=0.
- `wb_sel`  out  2  00 ALU, 01 MEM, 10 PC+4, 11 no writeback.
- `rwe`  out  1  register-file write enable, this cycle.
- `csr_we`  out  1  CSR write enable, this cycle.
- `w_commit`  out  1  W instruction retires this cycle.
- `instret`  out  `INSTRET_W`  count of retired instructions.

## Operation
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, ARI_I 0010011, ARI_R 0110011, CSR 1110011.
- Capture: at each edge with `w_stall`=0, the W register takes `x_opcode`, `x_funct3` and `x_rd`. It sets `w_valid` = `x_valid & ~flush`. With `w_stall`=1, the W register holds.
- `wb_sel` from the registered opcode:
  - ALU for CSR, AUIPC, LUI, ARI_R, ARI_I.
  - MEM for LOAD.
  - PC+4 for JAL, JALR.
  - 11 otherwise, and whenever `w_valid`=0.
- Write-enable class (`wr_cls`): AUIPC, LUI, ARI_R, ARI_I, LOAD, JAL, JALR. BRANCH, STORE, CSR and unknown opcodes have no register write.
- `rwe` = `w_valid & wr_cls & ~w_stall & (w_rd != 0)`.
- `csr_we` = `w_valid & (opcode==CSR) & (funct3==001 or funct3==101) & ~w_stall`. CSRRS, CSRRC and their immediate forms never write.
- `w_commit` = `w_valid & ~w_stall`. Unknown opcodes commit and are counted.
- `instret` increments by 1 on each `w_commit` and wraps modulo 2^`INSTRET_W`.
- Load FSM, states RUN and WAIT:
  - RUN→WAIT at the edge that captures a valid LOAD, except when `MEM_LAT`=1.
  - In WAIT, the load is done when `dmem_resp_valid`=1 (`MEM_LAT`=0), or when the down-counter reaches 1 (`MEM_LAT`≥2). The counter is loaded with `MEM_LAT` on entry and decrements each W cycle.
  - `w_stall` = WAIT & ~done. In the done cycle the load commits with `rwe` and the FSM returns to RUN. The next instruction is captured at that same edge.
- `dmem_resp_valid` is ignored outside WAIT. `flush` while `w_stall`=1 has no effect, because nothing is captured.

## Timing
- Reset values: state RUN, `w_valid` 0, `w_rd` 0, `wb_sel` 11, `rwe`/`csr_we`/`w_commit`/`w_stall` 0, `instret` 0, counter 0.
- Latency: X→W is 1 cycle. Non-load instructions spend exactly 1 cycle in W.
- Load residency in W:
  - `MEM_LAT`=N≥1: exactly N cycles; `w_stall` high for the first N−1.
  - `MEM_LAT`=0: 1 + number of cycles before `dmem_resp_valid`. A response in the first W cycle gives 1 cycle.
- All outputs except `instret` and the state are combinational from the W register, the FSM and `dmem_resp_valid`.
- Back-to-back loads: no bubble is required between them.
- Reset while in WAIT: the FSM returns to RUN next cycle, the load is dropped, no commit occurs and `instret` is 0.

## Test plan
- Reset asserted 2 cycles with `x_valid`=1 → all outputs at reset values. Deassert → the first instruction appears in W 1 cycle later.
- ADDI rd=5, then JAL rd=1, then SW → `wb_sel`=00 with `rwe`=1; `wb_sel`=10 with `rwe`=1; `wb_sel`=11 with `rwe`=0. `instret`=3.
- ADDI rd=0 → `rwe`=0, `w_commit`=1. `flush` together with `x_valid`=1 → `w_valid`=0 and `instret` unchanged.
- `MEM_LAT`=0: LW rd=7 with `dmem_resp_valid` in the 4th W cycle → `w_stall`=1 for 3 cycles. In cycle 4: `rwe`=1, `wb_sel`=01, `w_rd`=7. The following ADDI enters W in cycle 5.
- `MEM_LAT`=3: two back-to-back LWs → each stalls 2 cycles then commits. `instret`+=2 after 6 cycles. Repeat with reset in the 2nd stall cycle → no commit.
- CSRRW, CSRRWI, CSRRS → `csr_we`=1, 1, 0 respectively; all have `rwe`=0 and `wb_sel`=00. With `INSTRET_W`=4, 17 commits → `instret`=1.
